// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter and the calculator control FSM that consumes it.
package button_event_arbiter_pkg;

   // Default sizing of the arbiter
   localparam int unsigned DEF_NUM_BTN        = 5;
   localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;
   localparam int unsigned DEF_CNT_W          = 16;

   // Button indices as seen on btn_pulse and reported on evt_code
   localparam int unsigned BTN_DIGIT = 0;
   localparam int unsigned BTN_OP    = 1;
   localparam int unsigned BTN_EQ    = 2;
   localparam int unsigned BTN_CLR   = 3;
   localparam int unsigned BTN_NEXT  = 4;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_LOCKOUT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module button_event_arbiter_rr_pick
   import button_event_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_BTN = DEF_NUM_BTN,
   localparam int unsigned CODE_W  = $clog2(NUM_BTN)
) (
   input  logic [NUM_BTN-1:0] req,
   input  logic [CODE_W-1:0]  last,
   output logic               any,
   output logic [CODE_W-1:0]  idx
);

   // Index 'off' positions after 'base', modulo NUM_BTN (off never exceeds NUM_BTN)
   function automatic int wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      return (s >= int'(NUM_BTN)) ? (s - int'(NUM_BTN)) : s;
   endfunction

   // Scan from farthest to nearest so the nearest set request after 'last' wins
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = int'(NUM_BTN); k > 0; k--) begin
         if (req[CODE_W'(wrap_idx(int'(last), k))]) begin
            any = 1'b1;
            idx = CODE_W'(wrap_idx(int'(last), k));
         end
      end
   end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches debounced press pulses and serialises them, round-robin and rate-limited,
// into a single valid/ready event stream.
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_BTN        = DEF_NUM_BTN,
   parameter  int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter  int unsigned CNT_W          = DEF_CNT_W,
   localparam int unsigned CODE_W         = $clog2(NUM_BTN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_pulse,
   output logic               evt_valid,
   output logic [CODE_W-1:0]  evt_code,
   input  logic               evt_ready,
   output logic               overrun,
   output logic               busy
);

   localparam bit HAS_LOCKOUT = (LOCKOUT_CYCLES != 0);

   arb_state_e           state, state_d;
   logic [NUM_BTN-1:0]   pend, pend_d, clr;
   logic [CODE_W-1:0]    last_grant, last_grant_d;
   logic [CODE_W-1:0]    evt_code_d;
   logic                 evt_valid_d, overrun_d, busy_d;
   logic [CNT_W-1:0]     lock_cnt, lock_cnt_d;
   logic                 pick_any;
   logic [CODE_W-1:0]    pick_idx;

   button_event_arbiter_rr_pick #(
      .NUM_BTN (NUM_BTN)
   ) u_rr_pick (
      .req  (pend),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Next state, grant/accept/lockout decisions and next values of all registers
   always_comb begin
      state_d      = state;
      evt_valid_d  = evt_valid;
      evt_code_d   = evt_code;
      last_grant_d = last_grant;
      lock_cnt_d   = lock_cnt;
      clr          = '0;

      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               evt_code_d   = pick_idx;
               last_grant_d = pick_idx;
               clr          = NUM_BTN'(1) << pick_idx;
               evt_valid_d  = 1'b1;
               state_d      = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (evt_ready) begin
               evt_valid_d = 1'b0;
               if (HAS_LOCKOUT) begin
                  lock_cnt_d = CNT_W'(LOCKOUT_CYCLES);
                  state_d    = ST_LOCKOUT;
               end else begin
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_LOCKOUT: begin
            lock_cnt_d = lock_cnt - CNT_W'(1);
            if (lock_cnt == CNT_W'(1)) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new press on a bit being granted this cycle re-arms it (set wins)
      pend_d    = (pend & ~clr) | btn_pulse;
      overrun_d = |(btn_pulse & pend & ~clr);
      busy_d    = (state_d != ST_IDLE) || (|pend_d);
   end

   // Pending latch, grant bookkeeping, lockout counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pend       <= '0;
         last_grant <= CODE_W'(NUM_BTN - 1);
         lock_cnt   <= '0;
         evt_valid  <= 1'b0;
         evt_code   <= '0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         pend       <= pend_d;
         last_grant <= last_grant_d;
         lock_cnt   <= lock_cnt_d;
         evt_valid  <= evt_valid_d;
         evt_code   <= evt_code_d;
         overrun    <= overrun_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: directed scenarios plus random presses,
// checked against a time-based reference model of the arbitration rules.
module tb_button_event_arbiter;
   import button_event_arbiter_pkg::*;

   localparam int unsigned NB = 5;
   localparam int unsigned L  = 4;
   localparam int unsigned CW = $clog2(NB);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_pulse = '0;
   logic          evt_ready = 1'b0;
   logic          evt_valid, overrun, busy;
   logic [CW-1:0] evt_code;

   logic [NB-1:0] btn0 = '0;
   logic          rdy0 = 1'b0;
   logic          v0, ov0, b0;
   logic [CW-1:0] c0;

   always #5 clk = ~clk;

   button_event_arbiter #(.NUM_BTN(NB), .LOCKOUT_CYCLES(L), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .evt_valid(evt_valid),
      .evt_code(evt_code), .evt_ready(evt_ready), .overrun(overrun), .busy(busy));

   button_event_arbiter #(.NUM_BTN(NB), .LOCKOUT_CYCLES(0), .CNT_W(16)) u_l0 (
      .clk(clk), .reset(reset), .btn_pulse(btn0), .evt_valid(v0),
      .evt_code(c0), .evt_ready(rdy0), .overrun(ov0), .busy(b0));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model (absolute-time view of the rules) ----------------
   typedef struct { int code; int at; } exp_t;
   exp_t evq[$];
   int   ovq[$];
   bit   busy_exp[int];
   bit   m_pend[NB];
   int   m_last    = NB - 1;
   bit   m_valid   = 1'b0;
   int   m_next_ok = 0;

   task automatic model_step(input int c, input logic [NB-1:0] b, input bit rdy, input bit rst);
      int  g;
      bit  ov, acc, anyp;
      int  nb;
      nb = NB;
      if (rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_last = nb - 1; m_valid = 1'b0; m_next_ok = 0;
         evq.delete(); ovq.delete();
         busy_exp[c+1] = 1'b0;
         return;
      end
      g = -1; ov = 1'b0;
      acc = m_valid && rdy;
      if (!m_valid && c >= m_next_ok) begin
         for (int k = 1; k <= nb; k++) begin
            int i;
            i = (m_last + k) % nb;
            if (m_pend[i]) begin g = i; break; end
         end
      end
      for (int i = 0; i < nb; i++)
         if (b[i] && m_pend[i] && i != g) ov = 1'b1;
      if (g >= 0) begin
         evq.push_back('{code: g, at: c + 1});
         m_last = g; m_pend[g] = 1'b0; m_valid = 1'b1;
      end
      for (int i = 0; i < nb; i++) if (b[i]) m_pend[i] = 1'b1;
      if (ov) ovq.push_back(c + 1);
      if (acc) begin m_valid = 1'b0; m_next_ok = c + 1 + int'(L); end
      anyp = 1'b0;
      foreach (m_pend[i]) if (m_pend[i]) anyp = 1'b1;
      busy_exp[c+1] = m_valid || anyp || (c + 1 < m_next_ok);
   endtask

   // One clock of stimulus: drive just after the edge, inform the model
   task automatic step(input logic [NB-1:0] b, input bit r, input bit rst);
      @(posedge clk); #1;
      btn_pulse = b; evt_ready = r; reset = rst;
      model_step(cyc, b, r, rst);
   endtask

   task automatic idle(input int n, input bit r);
      repeat (n) step('0, r, 1'b0);
   endtask

   // ---------------- monitor: compares DUT outputs against the scoreboard ----------------
   bit mon_prev = 1'b0;
   always @(negedge clk) begin
      bit exp_ov;
      if (reset) begin
         mon_prev = 1'b0;
      end else begin
         if (busy_exp.exists(cyc)) chk(busy == busy_exp[cyc], "busy", int'(busy), int'(busy_exp[cyc]));
         if (evt_valid) begin
            chk(int'(evt_code) < int'(NB), "code_range", int'(evt_code), int'(NB) - 1);
            if (evq.size() == 0) begin
               chk(1'b0, "unexpected_event", int'(evt_code), -1);
            end else begin
               chk(int'(evt_code) == evq[0].code, "evt_code", int'(evt_code), evq[0].code);
               if (!mon_prev) chk(cyc == evq[0].at, "evt_cycle", cyc, evq[0].at);
               if (evt_ready) void'(evq.pop_front());
            end
            mon_prev = !evt_ready;
         end else begin
            mon_prev = 1'b0;
            if (evq.size() > 0 && evq[0].at <= cyc) begin
               chk(1'b0, "missing_event", -1, evq[0].code);
               void'(evq.pop_front());
            end
         end
         exp_ov = (ovq.size() > 0 && ovq[0] == cyc);
         chk(overrun == exp_ov, "overrun", int'(overrun), int'(exp_ov));
         if (exp_ov) void'(ovq.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      int t0;
      bit exp_v;
      int exp_c;

      repeat (3) step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b0);
      @(negedge clk);
      chk(evt_valid == 1'b0, "rst_evt_valid", int'(evt_valid), 0);
      chk(evt_code == '0, "rst_evt_code", int'(evt_code), 0);
      chk(overrun == 1'b0, "rst_overrun", int'(overrun), 0);
      chk(busy == 1'b0, "rst_busy", int'(busy), 0);
      chk(v0 == 1'b0, "rst_l0_valid", int'(v0), 0);

      // single press
      step(NB'(1) << BTN_EQ, 1'b1, 1'b0); idle(10, 1'b1);
      // backpressure
      step(NB'(1) << BTN_OP, 1'b0, 1'b0); idle(12, 1'b0); idle(10, 1'b1);
      // all buttons together, then 0 and 4 together
      step('1, 1'b1, 1'b0); idle(40, 1'b1);
      step((NB'(1) << BTN_DIGIT) | (NB'(1) << BTN_NEXT), 1'b1, 1'b0); idle(20, 1'b1);
      // overrun while presenting
      step(NB'(1) << BTN_CLR, 1'b0, 1'b0); idle(3, 1'b0);
      step(NB'(1) << BTN_CLR, 1'b0, 1'b0); idle(1, 1'b0);
      step(NB'(1) << BTN_CLR, 1'b0, 1'b0); idle(3, 1'b0); idle(20, 1'b1);
      // press captured during lockout
      step(NB'(1) << BTN_DIGIT, 1'b1, 1'b0); idle(3, 1'b1);
      step(NB'(1) << BTN_EQ, 1'b1, 1'b0); idle(15, 1'b1);
      // reset while presenting with other presses pending
      step(NB'(1) << BTN_DIGIT, 1'b0, 1'b0); idle(3, 1'b0);
      step(NB'(5'b01010), 1'b0, 1'b0); idle(1, 1'b0);
      step('0, 1'b0, 1'b1); idle(1, 1'b0);
      step(NB'(1) << BTN_NEXT, 1'b1, 1'b0); idle(10, 1'b1);

      // random presses, backpressure and occasional resets
      for (int n = 0; n < 3000; n++) begin
         logic [NB-1:0] b;
         b = ($urandom % 6 == 0) ? NB'($urandom) : '0;
         step(b, ($urandom % 10) < 6, ($urandom % 700) == 0);
      end

      // drain everything still pending
      guard = 0;
      while ((evq.size() > 0 || m_valid || cyc < m_next_ok || busy_exp[cyc+1]) && guard < 300) begin
         step('0, 1'b1, 1'b0);
         guard++;
      end
      chk(guard < 300, "drain_timeout", guard, 300);
      idle(2, 1'b1);
      chk(evq.size() == 0, "events_left", evq.size(), 0);

      // zero-lockout instance: back-to-back accepts two cycles apart
      @(posedge clk); #1;
      btn0 = NB'(5'b00011); rdy0 = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      btn0 = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_v = (k == 2) || (k == 4);
         exp_c = (k == 4) ? 1 : 0;
         chk(v0 == exp_v, "l0_valid", int'(v0), int'(exp_v));
         if (exp_v) chk(int'(c0) == exp_c, "l0_code", int'(c0), exp_c);
      end
      chk(cyc == t0 + 6, "l0_timing", cyc, t0 + 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
